rt_imp_sdiv_21s_12ns_9s_seq: RTL

Sequential signed divider that inverts the 12-bit-unsigned × 9-bit-signed → 21-bit-signed multiply path. It takes a 21-bit signed dividend and a 12-bit unsigned divisor and returns a saturated 9-bit signed quotient and a 13-bit signed remainder. It uses a restoring radix-2 datapath, resolves one bit per enabled cycle, and uses a start/done handshake. It sits beside the multiplier units in the generated accelerator datapath and shares their `ce` stall semantics.

---
 rtl/rt_imp_sdiv_21s_12ns_9s_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rt_imp_sdiv_21s_12ns_9s_seq.sv
// rt_imp_sdiv_21s_12ns_9s_seq
//
// Sequential signed divider: 21-bit signed dividend / 12-bit unsigned divisor
// -> saturated 9-bit signed quotient and 13-bit signed remainder. It is the
// inverse of the 12u x 9s -> 21s multiply path. A restoring radix-2 datapath
// resolves one quotient bit per enabled cycle. Results are registered.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high; clears all state and outputs
//   ce           clock enable; when low every register holds
//   start        operation request, accepted only in IDLE with ce high
//   din0 [20:0]  signed dividend, captured on acceptance
//   din1 [11:0]  unsigned divisor, captured on acceptance
//   busy         high while an operation is in flight
//   done         one-enabled-cycle pulse when results are valid
//   quotient     [8:0]  signed quotient, truncated toward zero, saturated
//   remainder    [12:0] signed remainder of the true quotient (dividend sign)
//   overflow     true quotient outside [-256, 255]
//   div_by_zero  divisor was zero

module rt_imp_sdiv_21s_12ns_9s_seq #(
    parameter logic [31:0] ID        = 32'd1,
    parameter logic [31:0] NUM_STAGE = 32'd23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic [20:0] din0,
    input  logic [11:0] din1,
    output logic        busy,
    output logic        done,
    output logic [8:0]  quotient,
    output logic [12:0] remainder,
    output logic        overflow,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic        neg_q,       neg_d;
    logic [20:0] dvd_q,       dvd_d;
    logic [11:0] div_q,       div_d;
    logic [12:0] rem_q,       rem_d;
    logic [20:0] qmag_q,      qmag_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic        done_q,      done_d;
    logic [8:0]  quotient_q,  quotient_d;
    logic [12:0] remainder_q, remainder_d;
    logic        overflow_q,  overflow_d;
    logic        dbz_q,       dbz_d;

    logic [20:0] abs_din0;
    logic [13:0] shifted;
    logic        trial_ge;
    logic [12:0] trial_sub;
    logic        q_ovf;
    logic [8:0]  q_signed;

    // |din0| as unsigned; -2^20 maps to 2^20, which still fits in 21 bits.
    assign abs_din0 = din0[20] ? (~din0 + 21'd1) : din0;

    // Restoring step: the partial remainder is always below the divisor, so
    // after the subtraction only the low 13 bits can be non-zero.
    assign shifted   = {rem_q, dvd_q[20]};
    assign trial_ge  = (shifted >= {2'b00, div_q});
    assign trial_sub = shifted[12:0] - {1'b0, div_q};

    // A negative result may reach -256, a positive one only 255.
    assign q_ovf    = neg_q ? (qmag_q > 21'd256) : (qmag_q > 21'd255);
    assign q_signed = neg_q ? (~qmag_q[8:0] + 9'd1) : qmag_q[8:0];

    // Next-state and datapath; everything holds unless ce is high.
    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        dvd_d       = dvd_q;
        div_d       = div_q;
        rem_d       = rem_q;
        qmag_d      = qmag_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;

        if (ce) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = CALC;
                        neg_d   = din0[20];
                        dvd_d   = abs_din0;
                        div_d   = din1;
                        rem_d   = 13'd0;
                        qmag_d  = 21'd0;
                        cnt_d   = 5'd0;
                    end
                end
                CALC: begin
                    dvd_d  = {dvd_q[19:0], 1'b0};
                    rem_d  = trial_ge ? trial_sub : shifted[12:0];
                    qmag_d = {qmag_q[19:0], trial_ge};
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd20) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    state_d = DONE;
                    if (div_q == 12'd0) begin
                        // Divide by zero: saturate toward the dividend's sign.
                        quotient_d  = neg_q ? 9'h100 : 9'h0FF;
                        remainder_d = 13'd0;
                        overflow_d  = 1'b0;
                        dbz_d       = 1'b1;
                    end else begin
                        if (q_ovf) begin
                            quotient_d = neg_q ? 9'h100 : 9'h0FF;
                        end else begin
                            quotient_d = q_signed;
                        end
                        remainder_d = neg_q ? (~rem_q + 13'd1) : rem_q;
                        overflow_d  = q_ovf;
                        dbz_d       = 1'b0;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            neg_q       <= 1'b0;
            dvd_q       <= 21'd0;
            div_q       <= 12'd0;
            rem_q       <= 13'd0;
            qmag_q      <= 21'd0;
            cnt_q       <= 5'd0;
            done_q      <= 1'b0;
            quotient_q  <= 9'd0;
            remainder_q <= 13'd0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            dvd_q       <= dvd_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            qmag_q      <= qmag_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule
